pending_priority_encoder: RTL and testbench
===========================================

Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the 4-to-2 combinational priority encoder.
- Captures one-cycle request pulses on N lines into a sticky pending register.
- Emits pending requests one at a time as binary codes, highest index first, through a valid/ready output handshake.
- Sits between event sources (interrupt-style pulses) and a single consumer that cannot accept every event in the cycle it occurs.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W (localparam), $clog2(N), width of the output code.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N  request pulses; bit i high in a cycle sets pending bit i.
- out_valid  output  1  out_code holds an undelivered request.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_code  output  W  index of the delivered request.
- pending  output  N  current pending register; read-only status.
- collide  output  1  registered pulse: a req_in bit hit an already-pending bit.

Behaviour:
- Reset (async assert, sync release):
  - pending = 0, out_valid = 0, out_code = 0, collide = 0, RR pointer = N-1.
  - Reset mid-handshake discards the held code and all pending bits.
- Load condition: load = !out_valid || out_ready. When load is true:
  - If pending != 0, out_code <= selected index c, out_valid <= 1, and bit c is cleared from pending.
  - Otherwise out_valid <= 0. out_code keeps its last value; it is don't-care while invalid.
- Hold: when out_valid && !out_ready, out_code and out_valid are stable and pending only accumulates.
- Pending update: pending_next = (pending & ~clr_mask) | req_in.
  - clr_mask is the one-hot of c on a load, else 0.
  - Set wins over clear: a req_in bit equal to c in the load cycle leaves the bit pending as a new event.
- Latency: req_in sampled at edge k sets pending at k. With an idle output, out_valid and out_code are valid after edge k+1 (2 edges from stimulus). Selection uses pending only, never req_in.
- Throughput: 1 code per cycle while out_ready = 1 and pending is non-zero.
- Coalescing: a req_in bit that is already pending (and not being cleared that cycle) merges into one event. collide = 1 for exactly the following cycle.
- Request on the bit currently held in out_code sets pending again; it is a distinct event and not a collision.
- Fixed priority: c = highest set index of pending.
- No combinational path from out_ready to out_valid or out_code.

Optional Feature:
- Macro: PENDING_PRIORITY_ENCODER_RR_EN
- Defined (round-robin):
  - Search starts at the RR pointer and descends modulo N.
  - After each load of c, pointer <= (c-1) mod N; c = 0 wraps the pointer to N-1.
  - The pointer is unchanged when nothing loads.
- Undefined: fixed highest-index priority; no pointer register is synthesised.

Decomposition:
- Package pending_priority_encoder_pkg: default N, a clog2-style width helper function, and the reset pointer constant (N-1).
- One sub-module, prio_find: combinational find-first-set.
  - Parameter N; inputs vec[N] and start[W]; outputs found and idx[W].
  - Searches from start downward with wrap.
  - Fixed mode ties start to N-1.

Test Plan:
- Reset: assert rst mid-stream with pending = 8'hA5 and out_valid = 1 -> all outputs and pending read 0 immediately, before any clock edge.
- Single pulse: req_in = 8'h08 for 1 cycle, out_ready = 1 -> out_valid = 1, out_code = 3 after the second edge; pending = 0 and out_valid = 0 one cycle later.
- Fixed order: req_in = 8'h96 in one cycle, out_ready = 1 -> codes 7, 4, 2, 1 on consecutive cycles, then out_valid = 0.
- Backpressure: pending = 8'h81, out_ready = 0 for 5 cycles -> out_code held at 7 and pending = 8'h01. Raise out_ready -> 7 is accepted, then 0.
- Collision and set-wins:
  - req_in = 8'h04 twice while bit 2 is pending -> collide pulses once; 2 is delivered only once.
  - req_in bit 5 in the cycle bit 5 loads -> code 5 is delivered twice.
- RR (macro defined): req_in = 8'hFF held for 1 cycle, then 8'h81 -> first pass yields 7..0; the following requests alternate 7, 0, 7, 0 without starving bit 0.

Source files
------------

// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and helpers for the pending priority encoder.
// Optional round-robin search: define PENDING_PRIORITY_ENCODER_RR_EN.
package pending_priority_encoder_pkg;

  localparam int N_DEFAULT = 8;

  // Code width for n request lines (same as $clog2 for n >= 2).
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return (w < 1) ? 1 : w;
  endfunction

  // Round-robin pointer value after reset: search starts at the top line.
  function automatic int rr_reset_ptr(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_if.sv
// Request/response bundle for the pending priority encoder.
// slave: the encoder side; master: the event source / consumer side.
interface pending_priority_encoder_if
  import pending_priority_encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int W = clog2w(N);

  logic [N-1:0] req_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic [N-1:0] pending;
  logic         collide;

  modport slave (
    input  req_in, out_ready,
    output out_valid, out_code, pending, collide
  );

  modport master (
    output req_in, out_ready,
    input  out_valid, out_code, pending, collide
  );

endinterface

// File: rtl/pending_priority_encoder_prio_find.sv
// Combinational find-first-set: scans vec from start downward, wrapping
// from 0 to N-1, and reports the first set index.
module prio_find
  import pending_priority_encoder_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = clog2w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (W+1)'(N) - (W+1)'(k);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (vec[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending register in front of a valid/ready code output.
// Request pulses accumulate; one pending index is emitted per load,
// highest index first (or round-robin with PENDING_PRIORITY_ENCODER_RR_EN).
module pending_priority_encoder
  import pending_priority_encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic clk,
  input logic rst,
  pending_priority_encoder_if.slave bus
);

  localparam int W = clog2w(N);

  logic [N-1:0] pending_q,   pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_code_q,  out_code_d;
  logic         collide_q,   collide_d;

  logic         load;
  logic         do_load;
  logic         found;
  logic [W-1:0] sel_idx;
  logic [W-1:0] start;
  logic [N-1:0] clr_mask;

`ifdef PENDING_PRIORITY_ENCODER_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = W'(N - 1);
`endif

  // Selection looks only at registered pending bits, never at req_in.
  prio_find #(.N(N)) u_find (
    .vec   (pending_q),
    .start (start),
    .found (found),
    .idx   (sel_idx)
  );

  // Output slot, pending accumulation and collision detect for the next edge.
  always_comb begin
    load        = !out_valid_q || bus.out_ready;
    do_load     = load && found;
    clr_mask    = '0;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (do_load) clr_mask[sel_idx] = 1'b1;
    if (load) out_valid_d = found;
    if (do_load) out_code_d = sel_idx;
    // Set wins over clear: a request on the bit being loaded is a new event.
    pending_d = (pending_q & ~clr_mask) | bus.req_in;
    // A hit on a bit that stays pending merges into the existing event.
    collide_d = |(bus.req_in & pending_q & ~clr_mask);
  end

`ifdef PENDING_PRIORITY_ENCODER_RR_EN
  // Next search starts just below the index just handed out.
  always_comb begin
    ptr_d = ptr_q;
    if (do_load) ptr_d = (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= W'(rr_reset_ptr(N));
    else     ptr_q <= ptr_d;
  end
`endif

  // State registers; reset drops any held code and all pending events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      collide_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      collide_q   <= collide_d;
    end
  end

  assign bus.pending   = pending_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.collide   = collide_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against an event-level reference model.
module tb_pending_priority_encoder;
  import pending_priority_encoder_pkg::*;

  localparam int N = 8;
  localparam int W = clog2w(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nfail = 0;

  pending_priority_encoder_if #(.N(N)) bus ();

  pending_priority_encoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_code;
  bit         m_col;
  int         m_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_pend = '0; m_valid = 0; m_code = 0; m_col = 0; m_ptr = N - 1;
  endtask

  // One clock of the event model: maybe hand out one pending index, then merge requests.
  task automatic mdl_step(input bit [N-1:0] req, input bit rdy);
    int c;
    c = -1;
    if (!m_valid || rdy) begin
`ifdef PENDING_PRIORITY_ENCODER_RR_EN
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr - k + N) % N;
        if (c < 0 && m_pend[i]) c = i;
      end
`else
      for (int i = N - 1; i >= 0; i--)
        if (c < 0 && m_pend[i]) c = i;
`endif
      if (c >= 0) begin
        m_valid = 1; m_code = c; m_ptr = (c + N - 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    m_col = 0;
    for (int i = 0; i < N; i++)
      if (req[i] && m_pend[i] && i != c) m_col = 1;
    if (c >= 0) m_pend[c] = 0;
    for (int i = 0; i < N; i++)
      if (req[i]) m_pend[i] = 1;
  endtask

  task automatic compare();
    chk("valid", bus.out_valid, m_valid);
    chk("pending", bus.pending, m_pend);
    chk("collide", bus.collide, m_col);
    if (m_valid) chk("code", bus.out_code, m_code);
  endtask

  // Drive one cycle, advance model at the edge, check 1 time unit later.
  task automatic cyc(input bit [N-1:0] req, input bit rdy);
    bus.req_in = req;
    bus.out_ready = rdy;
    @(posedge clk);
    mdl_step(req, rdy);
    #1;
    compare();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    mdl_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_code", bus.out_code, 0);
    chk("rst_pend", bus.pending, 0);
    chk("rst_col", bus.collide, 0);
    #1;
    rst = 1'b0;
  endtask

  int codes[$];

  initial begin
    bus.req_in = '0;
    bus.out_ready = 1'b0;
    mdl_reset();
    #2;
    chk("por_valid", bus.out_valid, 0);
    chk("por_pend", bus.pending, 0);
    #10;
    rst = 1'b0;

    // Reset while a code is held and pending = A5
    cyc(8'h80, 0);
    cyc(8'hA5, 0);
    chk("pre_rst_pend", bus.pending, 8'hA5);
    chk("pre_rst_valid", bus.out_valid, 1);
    do_reset();

    // Single pulse: code 3 after the second edge, then idle
    cyc(8'h08, 1);
    chk("single_v0", bus.out_valid, 0);
    cyc(8'h00, 1);
    chk("single_code", bus.out_code, 3);
    chk("single_v1", bus.out_valid, 1);
    cyc(8'h00, 1);
    chk("single_idle", bus.out_valid, 0);
    chk("single_pend", bus.pending, 0);

    // Fixed order from one burst
    cyc(8'h96, 1);
    codes.delete();
    for (int k = 0; k < 5; k++) begin
      cyc(8'h00, 1);
      if (bus.out_valid) codes.push_back(int'(bus.out_code));
    end
`ifndef PENDING_PRIORITY_ENCODER_RR_EN
    chk("order_n", codes.size(), 4);
    if (codes.size() == 4) begin
      chk("order0", codes[0], 7); chk("order1", codes[1], 4);
      chk("order2", codes[2], 2); chk("order3", codes[3], 1);
    end
`else
    chk("order_n", codes.size(), 4);
`endif

    // Backpressure: 7 held while 0 waits
    cyc(8'h81, 0);
    for (int k = 0; k < 5; k++) cyc(8'h00, 0);
    chk("bp_code", bus.out_code, 7);
    chk("bp_pend", bus.pending, 8'h01);
    cyc(8'h00, 1);
    chk("bp_next", bus.out_code, 0);
    cyc(8'h00, 1);
    chk("bp_done", bus.out_valid, 0);

    // Collision on an already-pending bit; 2 delivered once
    cyc(8'h80, 0);
    cyc(8'h04, 0);
    chk("col_first", bus.collide, 0);
    cyc(8'h04, 0);
    chk("col_hit", bus.collide, 1);
    cyc(8'h00, 0);
    chk("col_pulse", bus.collide, 0);
    cyc(8'h00, 1);
    chk("col_code2", bus.out_code, 2);
    cyc(8'h00, 1);
    chk("col_once", bus.out_valid, 0);

    // Set wins over clear: 5 delivered twice
    cyc(8'h20, 1);
    cyc(8'h20, 1);
    chk("sw_code_a", bus.out_code, 5);
    chk("sw_pend", bus.pending, 8'h20);
    chk("sw_nocol", bus.collide, 0);
    cyc(8'h00, 1);
    chk("sw_code_b", bus.out_code, 5);
    chk("sw_valid_b", bus.out_valid, 1);
    cyc(8'h00, 1);
    chk("sw_end", bus.out_valid, 0);

`ifdef PENDING_PRIORITY_ENCODER_RR_EN
    // Round-robin: full pass 7..0, then 7/0 alternate under constant 81
    do_reset();
    cyc(8'hFF, 1);
    codes.delete();
    for (int k = 0; k < 8; k++) begin
      cyc(8'h00, 1);
      codes.push_back(int'(bus.out_code));
    end
    for (int k = 0; k < 8; k++) chk("rr_pass", codes[k], 7 - k);
    codes.delete();
    for (int k = 0; k < 8; k++) begin
      cyc(8'h81, 1);
      if (bus.out_valid) codes.push_back(int'(bus.out_code));
    end
    for (int k = 1; k < codes.size(); k++)
      chk("rr_alt", (codes[k] != codes[k-1]), 1);
    chk("rr_has0", (codes.size() > 2), 1);
    cyc(8'h00, 1); cyc(8'h00, 1); cyc(8'h00, 1);
`endif

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bit [N-1:0] r;
      bit         rd;
      r  = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      rd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(r, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
